// File: rtl/tea_stream_adapter.sv
// Byte-stream front end for a TEA core: packs 8 bytes into a 64-bit block, drives the
// core control/data buses, waits for the result and streams it back out as 8 bytes.
module tea_stream_adapter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_i,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [1:0]  core_control,
    output logic [31:0] core_bus_a,
    output logic [31:0] core_bus_b,
    input  logic [31:0] core_out_a,
    input  logic [31:0] core_out_b,
    input  logic [1:0]  core_status,
    output logic        busy,
    output logic        error,
    input  logic        err_clr
);

    typedef enum logic [1:0] {ST_COLLECT, ST_WAIT, ST_RELEASE, ST_EMIT} state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic        r_mode;
    logic [9:0]  r_tmo;
    logic [63:0] r_out;
    logic [1:0]  r_ctrl;
    logic [31:0] r_bus_a;
    logic [31:0] r_bus_b;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic        r_error;

    logic        w_s_ready;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_match;
    logic        w_timeout;
    logic        w_release;
    logic        w_tmo_hit;
    logic [1:0]  w_expect;

    assign w_expect  = r_mode ? 2'd2 : 2'd1;
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_in_xfer    = 1'b0;
        w_out_xfer   = 1'b0;
        w_match      = 1'b0;
        w_timeout    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_s_ready = 1'b1;
                w_in_xfer = s_valid;
                if (s_valid && r_cnt == 3'd7) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A status arriving on the last allowed cycle still counts as success
                if (core_status == w_expect) begin
                    w_match      = 1'b1;
                    w_state_next = ST_RELEASE;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_COLLECT;
                end
            end
            ST_RELEASE: begin
                if (core_status == 2'd0) begin
                    w_release    = 1'b1;
                    w_state_next = ST_EMIT;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                w_out_xfer = m_ready;
                if (m_ready && r_cnt == 3'd7) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 3'd0;
            r_mode    <= 1'b0;
            r_tmo     <= 10'd0;
            r_out     <= 64'd0;
            r_ctrl    <= 2'd0;
            r_bus_a   <= 32'd0;
            r_bus_b   <= 32'd0;
            r_m_data  <= 8'd0;
            r_m_valid <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == ST_WAIT || r_state == ST_RELEASE) begin
                r_tmo <= r_tmo + 10'd1;
            end
            if (w_in_xfer) begin
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd0) begin
                    r_mode <= mode_i;
                end
                for (int k = 0; k < 4; k++) begin
                    if (r_cnt == 3'(k)) begin
                        r_bus_a[31-8*k -: 8] <= s_data;
                    end
                    if (r_cnt == 3'(k + 4)) begin
                        r_bus_b[31-8*k -: 8] <= s_data;
                    end
                end
                if (r_cnt == 3'd7) begin
                    r_ctrl <= w_expect;
                    r_tmo  <= 10'd0;
                end
            end
            if (w_match) begin
                r_out  <= {core_out_a, core_out_b};
                r_ctrl <= 2'd0;
            end
            // r_out[63:56] always holds the next byte still to be presented
            if (w_release) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_out[63:56];
                r_out     <= {r_out[55:0], 8'd0};
            end
            if (w_out_xfer) begin
                r_cnt    <= r_cnt + 3'd1;
                r_m_data <= r_out[63:56];
                r_out    <= {r_out[55:0], 8'd0};
                if (r_cnt == 3'd7) begin
                    r_m_valid <= 1'b0;
                end
            end
            if (w_timeout) begin
                r_error <= 1'b1;
                r_ctrl  <= 2'd0;
            end else if (err_clr) begin
                r_error <= 1'b0;
            end
        end
    end

    assign s_ready      = w_s_ready;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign core_control = r_ctrl;
    assign core_bus_a   = r_bus_a;
    assign core_bus_b   = r_bus_b;
    assign error        = r_error;
    assign busy         = !(r_state == ST_COLLECT && r_cnt == 3'd0);

endmodule

// File: tb/tb_tea_stream_adapter.sv
// Directed bench for tea_stream_adapter: stub/TEA core models, table-driven blocks,
// plus hand-written timeout, error-clear and mid-block reset sequences.
`timescale 1ns/1ps
module tb_tea_stream_adapter;

    localparam logic [31:0] K0 = 32'hA56BABCD, K1 = 32'h0000F00D;
    localparam logic [31:0] K2 = 32'h12345678, K3 = 32'hFEDCBA98;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_i;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  core_control;
    logic [31:0] core_bus_a, core_bus_b;
    logic [31:0] core_out_a, core_out_b;
    logic [1:0]  core_status;
    logic        busy, error, err_clr;
    int          stub_kind;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    tea_stream_adapter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .core_control(core_control), .core_bus_a(core_bus_a), .core_bus_b(core_bus_b),
        .core_out_a(core_out_a), .core_out_b(core_out_b), .core_status(core_status),
        .busy(busy), .error(error), .err_clr(err_clr)
    );

    function automatic logic [63:0] tea(input logic [63:0] v, input logic dec);
        logic [31:0] v0, v1, sum;
        v0 = v[63:32];
        v1 = v[31:0];
        if (!dec) begin
            sum = 32'd0;
            for (int r = 0; r < 32; r++) begin
                sum = sum + DELTA;
                v0 = v0 + ((((v1 << 4) + K0) ^ (v1 + sum)) ^ ((v1 >> 5) + K1));
                v1 = v1 + ((((v0 << 4) + K2) ^ (v0 + sum)) ^ ((v0 >> 5) + K3));
            end
        end else begin
            sum = 32'hC6EF3720;
            for (int r = 0; r < 32; r++) begin
                v1 = v1 - ((((v0 << 4) + K2) ^ (v0 + sum)) ^ ((v0 >> 5) + K3));
                v0 = v0 - ((((v1 << 4) + K0) ^ (v1 + sum)) ^ ((v1 >> 5) + K1));
                sum = sum - DELTA;
            end
        end
        return {v0, v1};
    endfunction

    // Core models: 0 = inverter, 1 = TEA, 2 = dead (never answers)
    always_comb begin
        core_status = 2'd0;
        {core_out_a, core_out_b} = 64'd0;
        case (stub_kind)
            0: begin
                core_status = core_control;
                {core_out_a, core_out_b} = ~{core_bus_a, core_bus_b};
            end
            1: begin
                core_status = core_control;
                {core_out_a, core_out_b} = tea({core_bus_a, core_bus_b}, core_control == 2'd2);
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic mode, input logic [63:0] blk, input bit gaps, input bit tmode);
        int i = 0;
        int cyc = 0;
        bit acc;
        m_ready = 1'b0;
        while (i < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = s_valid ? blk[63-8*i -: 8] : 8'($urandom);
            mode_i  = (i == 0) ? mode : (tmode ? ~mode : mode);
            chk("s_ready_collect", {63'd0, s_ready}, 64'd1);
            if (i > 0) chk("busy_collect", {63'd0, busy}, 64'd1);
            acc = s_valid && s_ready;
            if (acc) i++;
        end
        if (i < 8) chk("send_bound", 64'(i), 64'd8);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_after_send(input logic mode, input logic [63:0] blk);
        chk("core_control", {62'd0, core_control}, mode ? 64'd2 : 64'd1);
        chk("core_bus_a", {32'd0, core_bus_a}, {32'd0, blk[63:32]});
        chk("core_bus_b", {32'd0, core_bus_b}, {32'd0, blk[31:0]});
        chk("s_ready_wait", {63'd0, s_ready}, 64'd0);
        chk("m_valid_wait", {63'd0, m_valid}, 64'd0);
        @(negedge clk);
        chk("m_valid_release", {63'd0, m_valid}, 64'd0);
        chk("s_ready_release", {63'd0, s_ready}, 64'd0);
        chk("ctrl_cleared", {62'd0, core_control}, 64'd0);
        @(negedge clk);
        chk("first_byte_latency", {63'd0, m_valid}, 64'd1);
    endtask

    task automatic recv(input logic [63:0] exp, input int n, input bit mtog, output logic [63:0] got);
        int  j = 0;
        int  cyc = 0;
        bit  hold = 0;
        bit  ph = 0;
        logic [7:0] held = 8'd0;
        got = 64'd0;
        while (j < n && cyc < 200) begin
            chk("s_ready_emit", {63'd0, s_ready}, 64'd0);
            chk("m_valid_emit", {63'd0, m_valid}, 64'd1);
            if (hold) chk("m_data_stable", {56'd0, m_data}, {56'd0, held});
            m_ready = mtog ? ph : 1'b1;
            ph = ~ph;
            if (m_valid && m_ready) begin
                chk("m_byte", {56'd0, m_data}, {56'd0, exp[63-8*j -: 8]});
                got[63-8*j -: 8] = m_data;
                j++;
                hold = 0;
            end else begin
                hold = m_valid;
                held = m_data;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (j < n) chk("recv_bound", 64'(j), 64'(n));
        if (n == 8) begin
            chk("m_valid_done", {63'd0, m_valid}, 64'd0);
            chk("busy_done", {63'd0, busy}, 64'd0);
            chk("s_ready_done", {63'd0, s_ready}, 64'd1);
        end
    endtask

    task automatic run_block(input logic mode, input logic [63:0] din, input logic [63:0] dout,
                             input bit gaps, input bit mtog, input bit tmode, output logic [63:0] got);
        send(mode, din, gaps, tmode);
        check_after_send(mode, din);
        recv(dout, 8, mtog, got);
        $display("block mode=%0d in=%h out=%h", mode, din, got);
    endtask

    task automatic timeout_block(input bit clr_high, input logic [63:0] din);
        stub_kind = 2;
        send(1'b0, din, 0, 0);
        chk("tmo_ctrl", {62'd0, core_control}, 64'd1);
        err_clr = clr_high;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("tmo_m_valid", {63'd0, m_valid}, 64'd0);
            if (k < 16) begin
                chk("tmo_err_early", {63'd0, error}, 64'd0);
                chk("tmo_s_ready", {63'd0, s_ready}, 64'd0);
            end else begin
                chk("tmo_err_set", {63'd0, error}, 64'd1);
                chk("tmo_ctrl_zero", {62'd0, core_control}, 64'd0);
                chk("tmo_back_collect", {63'd0, s_ready}, 64'd1);
                chk("tmo_busy", {63'd0, busy}, 64'd0);
            end
        end
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_sticky", {63'd0, error}, 64'd1);
        chk("tmo_no_output", {63'd0, m_valid}, 64'd0);
        $display("timeout block clr_high=%0d error=%0d", clr_high, error);
        stub_kind = 0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", {63'd0, error}, 64'd0);
    endtask

    typedef struct {
        logic        mode;
        logic [63:0] din;
        logic [63:0] dout;
        bit          gaps;
        bit          mtog;
        bit          tmode;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] got, ct;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
        mode_i = 1'b0; err_clr = 1'b0; stub_kind = 0;

        vecs[0] = '{1'b1, 64'h0001020304050607, 64'hFFFEFDFCFBFAF9F8, 0, 0, 0};
        vecs[1] = '{1'b0, 64'hA55A00FF12348001, 64'h5AA5FF00EDCB7FFE, 1, 1, 0};
        vecs[2] = '{1'b0, 64'h0011223344556677, 64'hFFEEDDCCBBAA9988, 0, 0, 1};
        vecs[3] = '{1'b1, 64'hDEADBEEFCAFEF00D, 64'h2152411035010FF2, 1, 1, 1};

        repeat (2) @(negedge clk);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", {56'd0, m_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_ctrl", {62'd0, core_control}, 64'd0);
        chk("rst_bus", {core_bus_a, core_bus_b}, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].mode, vecs[v].din, vecs[v].dout,
                      vecs[v].gaps, vecs[v].mtog, vecs[v].tmode, got);
        end

        stub_kind = 1;
        ct = tea(64'h0123456789ABCDEF, 1'b0);
        run_block(1'b0, 64'h0123456789ABCDEF, ct, 0, 0, 0, got);
        run_block(1'b1, got, 64'h0123456789ABCDEF, 1, 1, 0, got);
        stub_kind = 0;

        timeout_block(0, 64'h1111111111111111);
        run_block(1'b1, vecs[0].din, vecs[0].dout, 0, 0, 0, got);
        chk("err_survives_block", {63'd0, error}, 64'd1);
        pulse_clr();

        timeout_block(1, 64'h2222222222222222);
        pulse_clr();

        send(1'b0, 64'h0F1E2D3C4B5A6978, 0, 0);
        check_after_send(1'b0, 64'h0F1E2D3C4B5A6978);
        recv(64'hF0E1D2C3B4A59687, 3, 0, got);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("arst_m_data", {56'd0, m_data}, 64'd0);
        chk("arst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_ctrl", {62'd0, core_control}, 64'd0);
        chk("arst_bus", {core_bus_a, core_bus_b}, 64'd0);
        $display("reset during emit, partial out=%h", got);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1'b1, 64'h8877665544332211, 64'h778899AABBCCDDEE, 0, 1, 0, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
